// File: rtl/uart_fifo_lvl_pkg.sv
// uart_fifo_lvl_pkg: shared defaults and depth helper for the UART FIFOs
package uart_fifo_lvl_pkg;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_ADDR_W  = 4;
    localparam int RX_AF_LEVEL = 12;
    localparam int RX_AE_LEVEL = 2;
    localparam int TX_AF_LEVEL = 12;
    localparam int TX_AE_LEVEL = 2;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction
endpackage

// File: rtl/uart_fifo_lvl_if.sv
// uart_fifo_lvl_if: host-side FIFO bus; master drives requests, slave is the FIFO
interface uart_fifo_lvl_if
    import uart_fifo_lvl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              flush;
    logic              wr;
    logic [DATA_W-1:0] w_data;
    logic              rd;
    logic              clr_err;
    logic [DATA_W-1:0] r_data;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, wr, w_data, rd, clr_err,
        input  r_data, empty, full, almost_full, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  flush, wr, w_data, rd, clr_err,
        output r_data, empty, full, almost_full, almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/uart_fifo_lvl_ram.sv
// uart_fifo_lvl_ram: register file, synchronous write and asynchronous read
module uart_fifo_lvl_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [1 << ADDR_W];

    // store the incoming word; contents are never cleared
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/uart_fifo_lvl.sv
// uart_fifo_lvl: show-ahead FIFO with occupancy, threshold flags and sticky errors
module uart_fifo_lvl
    import uart_fifo_lvl_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int AF_LEVEL = RX_AF_LEVEL,
    parameter int AE_LEVEL = RX_AE_LEVEL
) (
    input logic            clk,
    input logic            rst,
    uart_fifo_lvl_if.slave bus
);
    localparam int DEPTH = fifo_depth(ADDR_W);

    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("uart_fifo_lvl: AF_LEVEL outside 1..depth");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("uart_fifo_lvl: AE_LEVEL outside 0..depth-1");
    end

    logic [ADDR_W-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              is_full, is_empty, wr_ok, rd_ok;

    assign is_full  = level_q == (ADDR_W+1)'(DEPTH);
    assign is_empty = level_q == '0;

    // accept decisions and next state; flush clears everything but the memory
    always_comb begin
        wr_ok   = bus.wr && (!is_full || bus.rd);
        rd_ok   = bus.rd && !is_empty;
        w_ptr_d = bus.flush ? '0 : wr_ok ? w_ptr_q + 1'b1 : w_ptr_q;
        r_ptr_d = bus.flush ? '0 : rd_ok ? r_ptr_q + 1'b1 : r_ptr_q;
        level_d = bus.flush ? '0 :
                  (wr_ok && !rd_ok) ? level_q + 1'b1 :
                  (rd_ok && !wr_ok) ? level_q - 1'b1 : level_q;
        ovf_d   = !bus.flush && ((bus.wr && !wr_ok) || (ovf_q && !bus.clr_err));
        unf_d   = !bus.flush && ((bus.rd && !rd_ok) || (unf_q && !bus.clr_err));
    end

    // state registers with active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    uart_fifo_lvl_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk     (clk),
        .we_i    (wr_ok && rst && !bus.flush),
        .waddr_i (w_ptr_q),
        .wdata_i (bus.w_data),
        .raddr_i (r_ptr_q),
        .rdata_o (bus.r_data)
    );

    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_full  = level_q >= (ADDR_W+1)'(AF_LEVEL);
    assign bus.almost_empty = level_q <= (ADDR_W+1)'(AE_LEVEL);
    assign bus.level        = level_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule
